// File: rtl/ssp_rx_logic.sv
// SSP serial receive path: edge-detects the master's serial clock in the PCLK domain and
// deserialises MSB-first frames into RxData. Define SSP_RX_SYNC_EN for a two-flop input synchronizer.
module ssp_rx_logic (
  input  logic       PCLK,
  input  logic       CLEAR,
  input  logic       SSE,
  input  logic       SSPCLKIN,
  input  logic       SSPFSSIN,
  input  logic       SSPRXD,
  input  logic       SSPRXINTR,
  input  logic       PSEL,
  input  logic       PWRITE,
  output logic [7:0] RxData,
  output logic       fin,
  output logic       BUSY,
  output logic       RXOR
);

`ifdef SSP_RX_SYNC_EN
  localparam int SyncDepth = 2;
`else
  localparam int SyncDepth = 1;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  // Bit order in every pipeline word: {sclk, fss, rxd}; all three share one depth.
  logic [2:0] pipe_in;
  logic [2:0] sync_q [SyncDepth];
  logic [2:0] hist_q;

  logic       sclk_fall;
  logic       fss_s;
  logic       rxd_s;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [7:0] shift_q;
  logic [7:0] rx_data_q;
  logic       done_q;
  logic       fin_q;
  logic       busy_q;
  logic       rxor_q;

  assign pipe_in = {SSPCLKIN, SSPFSSIN, SSPRXD};

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      for (int i = 0; i < SyncDepth; i++) sync_q[i] <= 3'b000;
      hist_q <= 3'b000;
    end else begin
      sync_q[0] <= pipe_in;
      for (int i = 1; i < SyncDepth; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SyncDepth-1];
    end
  end

  // Data is taken from the history stage, i.e. the last sample while the serial clock was still high.
  assign sclk_fall = hist_q[2] & ~sync_q[SyncDepth-1][2];
  assign fss_s     = hist_q[1];
  assign rxd_s     = hist_q[0];

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      shift_q   <= 8'h00;
      rx_data_q <= 8'h00;
      done_q    <= 1'b0;
      fin_q     <= 1'b0;
      busy_q    <= 1'b0;
      rxor_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fin_q  <= done_q;
      // A pop in the same cycle as the write frees a slot, so that write is not an overrun.
      if (fin_q && SSPRXINTR && !(PSEL && !PWRITE)) rxor_q <= 1'b1;

      if (!SSE) begin
        state_q <= IDLE;
        cnt_q   <= 3'd0;
        shift_q <= 8'h00;
        busy_q  <= 1'b0;
      end else if (sclk_fall) begin
        case (state_q)
          IDLE: begin
            if (fss_s) begin
              state_q <= SHIFT;
              cnt_q   <= 3'd0;
              busy_q  <= 1'b1;
            end
          end
          SHIFT: begin
            shift_q <= {shift_q[6:0], rxd_s};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_q <= {shift_q[6:0], rxd_s};
              done_q    <= 1'b1;
              if (fss_s) begin
                cnt_q <= 3'd0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign RxData = rx_data_q;
  assign fin    = fin_q;
  assign BUSY   = busy_q;
  assign RXOR   = rxor_q;

endmodule
